// File: rtl/pack_send_fifo_if.sv
// Packet-port and byte-stream signals between trace interface,
// frame packer and serial handler.
interface pack_send_fifo_if;
    logic        sync;
    logic        PacketAvail;
    logic        PacketNext;
    logic        PacketNextWd;
    logic [15:0] PacketIn;
    logic        DataAvail;
    logic [7:0]  DataVal;
    logic        DataNext;

    modport slave (
        input  sync, PacketAvail, PacketIn, DataNext,
        output PacketNext, PacketNextWd, DataAvail, DataVal
    );

    modport master (
        output sync, PacketAvail, PacketIn, DataNext,
        input  PacketNext, PacketNextWd, DataAvail, DataVal
    );
endinterface

// File: rtl/pack_send_fifo.sv
// Frame-to-byte packer: fetches fixed-length word frames into a byte FIFO
// with atomic per-frame commit and a show-ahead byte output.
module pack_send_fifo #(
    parameter int          FRAME_WORDS     = 8,
    parameter int          FIFO_DEPTH_LOG2 = 10,
    parameter bit          FILTER_PAD      = 1'b1,
    parameter logic [23:0] OVF_STRETCH     = 24'd4_800_000
) (
    input  logic                     clk,
    input  logic                     rst,
    pack_send_fifo_if.slave          bus,
    output logic                     DataOverf,
    output logic [15:0]              DropCount,
    output logic [FIFO_DEPTH_LOG2:0] Level
);
    localparam int          AW     = FIFO_DEPTH_LOG2;
    localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] FBYTES = (AW+1)'(2 * FRAME_WORDS);
    localparam logic [4:0]  LAST_W = 5'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, CLAIM, WORDS, COMMIT} state_t;
    state_t state, state_nx;

    // Word-wide array: the write pointer only ever moves in whole words.
    logic [15:0]   mem [0:(1 << (AW-1)) - 1];
    logic [AW-1:0] wr_sh, wr_cm, rd_ptr, rd_nx;
    logic [AW:0]   level_nx, free;
    logic [4:0]    wcnt;
    logic [23:0]   ovf_cnt;
    logic          keep, all_pad, last, pop;
    logic          commit, rollback, drop;
    logic [15:0]   rd_word;
    logic [7:0]    rd_byte;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.PacketAvail && bus.sync) state_nx = CLAIM;
            CLAIM:   state_nx = WORDS;
            WORDS:   if (last) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign last     = (wcnt == LAST_W);
    assign free     = DEPTH - Level;
    assign pop      = bus.DataNext && bus.DataAvail;
    assign commit   = (state == COMMIT) && keep && !(FILTER_PAD && all_pad);
    assign rollback = (state == COMMIT) && keep && FILTER_PAD && all_pad;
    assign drop     = (state == COMMIT) && !keep;
    assign level_nx = Level + (commit ? FBYTES : '0) - (AW+1)'(pop);
    assign rd_nx    = rd_ptr + AW'(pop);
    assign rd_word  = mem[rd_nx[AW-1:1]];
    assign rd_byte  = rd_nx[0] ? rd_word[15:8] : rd_word[7:0];

    assign bus.PacketNext   = (state == CLAIM);
    assign bus.PacketNextWd = (state == WORDS) && !last;
    assign DataOverf        = (ovf_cnt != '0);

    always_ff @(posedge clk) begin
        if ((state == WORDS) && keep) mem[wr_sh[AW-1:1]] <= bus.PacketIn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sh         <= '0;
            wr_cm         <= '0;
            rd_ptr        <= '0;
            Level         <= '0;
            wcnt          <= '0;
            keep          <= 1'b0;
            all_pad       <= 1'b0;
            ovf_cnt       <= '0;
            DropCount     <= '0;
            bus.DataAvail <= 1'b0;
            bus.DataVal   <= '0;
        end else begin
            Level         <= level_nx;
            rd_ptr        <= rd_nx;
            bus.DataAvail <= (level_nx != '0);
            bus.DataVal   <= (level_nx != '0) ? rd_byte : 8'h00;
            if (state == CLAIM) begin
                keep    <= (free >= FBYTES);
                all_pad <= 1'b1;
                wcnt    <= '0;
            end
            if (state == WORDS) begin
                wcnt    <= wcnt + 5'd1;
                all_pad <= all_pad && (bus.PacketIn == 16'h7FFF);
                if (keep) wr_sh <= wr_sh + AW'(2);
            end
            if (commit)   wr_cm <= wr_sh;
            if (rollback) wr_sh <= wr_cm;
            if (drop && (DropCount != 16'hFFFF)) DropCount <= DropCount + 16'd1;
            if (drop)                 ovf_cnt <= OVF_STRETCH;
            else if (ovf_cnt != '0)   ovf_cnt <= ovf_cnt - 24'd1;
        end
    end
endmodule

// File: doc/pack_send_fifo.md
Name: pack_send_fifo

Overview:
Parametrised successor to the packet-to-byte splitter between the trace interface and the UART/serial transmitter. Fetches fixed-length frames of 16-bit words from the trace-interface packet port and stages them in a byte FIFO, low byte first, with atomic per-frame commit. Can optionally discard pure-padding frames. Counts frames dropped for lack of space and stretches an overflow indication for an LED. Presents a byte-wide show-ahead stream to the serial handler.

Parameters:
FRAME_WORDS, 8, 16-bit words per frame (2..16)
FIFO_DEPTH_LOG2, 10, log2 of FIFO byte capacity (2^FIFO_DEPTH_LOG2 >= 2*FRAME_WORDS)
FILTER_PAD, 1, 1 = discard frames whose every word is 16'h7FFF
OVF_STRETCH, 24'd4_800_000, clk cycles DataOverf is held after the last drop

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sync  in  1  trace interface is in sync
PacketAvail  in  1  a complete frame is available upstream
PacketNext  out  1  one-cycle strobe: claim next frame
PacketNextWd  out  1  one-cycle strobe: advance to next word of claimed frame
PacketIn  in  16  current frame word
DataAvail  out  1  committed byte available
DataVal  out  8  head byte, valid while DataAvail=1
DataNext  in  1  consume head byte
DataOverf  out  1  stretched overflow indication
DropCount  out  16  saturating count of frames dropped for space
Level  out  FIFO_DEPTH_LOG2+1  committed byte count

Behaviour:
- One clock domain (clk); reset synchronous, active-high.
- Reset: PacketNext=0, PacketNextWd=0, DataAvail=0, DataVal=0, DataOverf=0, DropCount=0, Level=0. Read, write and shadow pointers are 0 and the FSM is IDLE.
- Reset mid-frame discards all FIFO contents and any partially fetched frame.
- Fetch FSM states: IDLE, CLAIM, WORDS, COMMIT.
- IDLE -> CLAIM when PacketAvail=1 and sync=1. CLAIM asserts PacketNext for exactly one cycle, then moves to WORDS.
  - The space check is made in CLAIM against free = 2^FIFO_DEPTH_LOG2 - Level.
  - If free >= 2*FRAME_WORDS, the frame is "kept"; otherwise it is "dropped".
- WORDS: word k (k = 0..FRAME_WORDS-1) is sampled from PacketIn in the k-th WORDS cycle.
  - PacketNextWd=1 in the same cycle for k < FRAME_WORDS-1 and 0 on the last word.
  - A kept frame writes PacketIn[7:0], then PacketIn[15:8], at the shadow write pointer. This takes 2 bytes per cycle, so the memory needs 2 write ports or a 16-bit-wide array.
  - A dropped frame samples without writing.
- WORDS -> COMMIT after the last word.
- COMMIT lasts one cycle, then returns to IDLE:
  - Kept frame, not all words 16'h7FFF, or FILTER_PAD=0: committed write pointer := shadow pointer, and Level += 2*FRAME_WORDS.
  - Kept frame, all words 16'h7FFF, and FILTER_PAD=1: shadow pointer := committed pointer (rollback); Level unchanged.
  - Dropped frame: DropCount += 1, saturating at 16'hFFFF; the stretch counter reloads to OVF_STRETCH.
- sync falling while in CLAIM/WORDS: the claimed frame completes and commits normally; no new claim is made while sync=0.
- Frame latency: the last word is sampled in cycle t; COMMIT runs in t+1; DataAvail=1 from t+2 if the FIFO was empty.
- Output side (show-ahead):
  - DataAvail = (Level != 0), registered.
  - DataVal holds the head byte whenever DataAvail=1.
  - DataNext with DataAvail=1 pops one byte; DataVal shows the next byte on the following cycle.
  - DataNext with DataAvail=0 is ignored.
- Pointer wrap: all pointers wrap modulo 2^FIFO_DEPTH_LOG2. A frame may straddle the wrap point.
- Simultaneous COMMIT and pop: Level += 2*FRAME_WORDS - 1 in that cycle. The space check in CLAIM uses the Level registered in that cycle.
- Never overwrites committed data; Level never exceeds 2^FIFO_DEPTH_LOG2.
- DataOverf = (stretch counter != 0). The counter decrements by 1 per cycle to 0; a new drop reloads it.

Test Plan:
- Frame of words 0x0100,0x0302,...,0x0F0E with a continuous DataNext sink -> PacketNext one pulse, PacketNextWd 7 pulses; bytes 0x00..0x0F out in order; DataAvail rises 2 cycles after the last word; Level returns to 0.
- Frame of eight 0x7FFF words, FILTER_PAD=1 -> no bytes output, Level stays 0, DropCount 0; same frame with FILTER_PAD=0 -> sixteen bytes 0xFF,0x7F alternating.
- DataNext held 0, depth 2^5=32, three frames offered -> frames 1 and 2 kept (Level=32); frame 3 drained from upstream (8 word samples) but dropped; DropCount=1; DataOverf=1 for OVF_STRETCH cycles, then 0.
- Pre-load write pointer to 24 (depth 32) by push/pop, then one frame -> bytes written across the wrap and read back in order, no corruption.
- sync driven low in the 3rd WORDS cycle -> frame still committed (16 bytes); a further PacketAvail with sync=0 produces no PacketNext.
- rst asserted in the 4th WORDS cycle with Level=10 -> next cycle all outputs 0, Level 0, FSM IDLE; a subsequent frame transfers cleanly.
